// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 convolutional encoder that feeds the Viterbi decoder.
// Accepts one information bit per input handshake and emits one 2-bit coded
// symbol per output handshake through a single output register stage. Each
// frame starts in trellis state 0. When TAIL_EN is set, M zero tail bits are
// appended so that each frame also ends in state 0.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  information bit handshake (in_bit, in_last)
//   out_valid/ready coded symbol handshake (out_sym = {c1,c0}, out_last, out_tail)
//   enc_state       shift-register contents after the latest update
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | between frames, sr = 0, waiting for the first bit of a frame
// DATA   | inside a frame, accepting information bits
// TAIL   | flushing M zero bits, input held off (in_ready = 0)

module conv_encoder #(
   parameter int             K       = 5,
   parameter int             M       = K - 1,
   parameter logic [K-1:0]   G0      = 5'b10011,
   parameter logic [K-1:0]   G1      = 5'b11101,
   parameter int             TAIL_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_bit,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   out_sym,
   output logic         out_last,
   output logic         out_tail,
   output logic [M-1:0] enc_state
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;

   logic [1:0]    state;
   logic [M-1:0]  sr;
   logic [CW-1:0] tail_cnt;

   logic          adv;
   logic          accept;
   logic          b;
   logic [K-1:0]  u;
   logic [M-1:0]  sr_next;
   logic [1:0]    sym_next;

   // The output is one register deep: advance only when it is empty or
   // being drained this cycle.
   assign adv      = !out_valid || out_ready;
   assign in_ready = (state != S_TAIL) && adv;
   assign accept   = in_valid && in_ready;

   assign b        = (state == S_TAIL) ? 1'b0 : in_bit;
   assign u        = {sr, b};
   assign sr_next  = {sr[M-2:0], b};
   assign sym_next = {^(G1 & u), ^(G0 & u)};

   assign enc_state = sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sr        <= '0;
         tail_cnt  <= '0;
         out_valid <= 1'b0;
         out_sym   <= 2'b00;
         out_last  <= 1'b0;
         out_tail  <= 1'b0;
      end else begin
         // Drained with nothing new behind it; overridden below if a new
         // symbol is registered in the same cycle.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            S_IDLE, S_DATA: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  out_sym   <= sym_next;
                  out_tail  <= 1'b0;
                  if (in_last) begin
                     if (TAIL_EN != 0) begin
                        state    <= S_TAIL;
                        sr       <= sr_next;
                        out_last <= 1'b0;
                     end else begin
                        // Without a tail the frame closes here, so the next
                        // frame must restart from state 0.
                        state    <= S_IDLE;
                        sr       <= '0;
                        out_last <= 1'b1;
                     end
                  end else begin
                     state    <= S_DATA;
                     sr       <= sr_next;
                     out_last <= 1'b0;
                  end
               end
            end

            S_TAIL: begin
               if (adv) begin
                  out_valid <= 1'b1;
                  out_sym   <= sym_next;
                  out_tail  <= 1'b1;
                  sr        <= sr_next;
                  if (tail_cnt == CW'(M - 1)) begin
                     out_last <= 1'b1;
                     tail_cnt <= '0;
                     state    <= S_IDLE;
                  end else begin
                     out_last <= 1'b0;
                     tail_cnt <= tail_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state    <= S_IDLE;
               sr       <= '0;
               tail_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

   localparam int           K  = 5;
   localparam int           M  = 4;
   localparam logic [4:0]   G0 = 5'b10011;
   localparam logic [4:0]   G1 = 5'b11101;

   logic clk = 1'b0;
   logic rst;

   // instance with tail
   logic       in_valid, in_ready, in_bit, in_last;
   logic       out_valid, out_ready, out_last, out_tail;
   logic [1:0] out_sym;
   logic [3:0] enc_state;

   // instance without tail
   logic       in_valid_z, in_ready_z, in_bit_z, in_last_z;
   logic       out_valid_z, out_ready_z, out_last_z, out_tail_z;
   logic [1:0] out_sym_z;
   logic [3:0] enc_state_z;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_encoder #(.K(K), .M(M), .G0(G0), .G1(G1), .TAIL_EN(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
      .out_last(out_last), .out_tail(out_tail), .enc_state(enc_state)
   );

   conv_encoder #(.K(K), .M(M), .G0(G0), .G1(G1), .TAIL_EN(0)) dut_z (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_z), .in_ready(in_ready_z), .in_bit(in_bit_z), .in_last(in_last_z),
      .out_valid(out_valid_z), .out_ready(out_ready_z), .out_sym(out_sym_z),
      .out_last(out_last_z), .out_tail(out_tail_z), .enc_state(enc_state_z)
   );

   // stimulus: bits of one or more frames, in_last marks frame ends
   logic tx_bit[$];
   logic tx_last[$];
   // expected symbol stream
   logic [1:0] exp_sym[$];
   logic       exp_tail[$];
   logic       exp_last[$];
   // received symbol stream
   logic [1:0] rx_sym[$];
   logic       rx_tail[$];
   logic       rx_last[$];
   int         rx_cyc[$];
   int         acc_cyc[$];
   int         ready_low;

   logic [1:0] imp_sym[5];
   logic       imp_tail[5];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each symbol is the GF(2) convolution of the frame's bit
   // sequence (zero before the frame, zero-padded by the tail) with G0/G1.
   task automatic build_expected(input bit tail_en);
      int first;
      int n;
      int len;
      exp_sym.delete(); exp_tail.delete(); exp_last.delete();
      first = 0;
      for (int p = 0; p < tx_bit.size(); p++) begin
         if (tx_last[p]) begin
            n   = p - first + 1;
            len = n + (tail_en ? M : 0);
            for (int t = 0; t < len; t++) begin
               logic c0, c1, x;
               c0 = 1'b0; c1 = 1'b0;
               for (int i = 0; i < K; i++) begin
                  int j;
                  j = t - i;
                  x = (j >= 0 && j < n) ? tx_bit[first + j] : 1'b0;
                  c0 = c0 ^ (G0[i] & x);
                  c1 = c1 ^ (G1[i] & x);
               end
               exp_sym.push_back({c1, c0});
               exp_tail.push_back(t >= n);
               exp_last.push_back(t == len - 1);
            end
            first = p + 1;
         end
      end
   endtask

   // Drive tx_* through the tail instance, collecting every accepted symbol
   // and checking the hold rule whenever the output is stalled.
   task automatic run(input bit stall, input int budget);
      int  idx;
      int  nframes;
      int  done;
      bit  held;
      logic [1:0] h_sym;
      logic       h_last, h_tail;
      rx_sym.delete(); rx_tail.delete(); rx_last.delete(); rx_cyc.delete();
      acc_cyc.delete();
      ready_low = 0;
      idx = 0; done = 0; held = 0;
      h_sym = 2'b00; h_last = 1'b0; h_tail = 1'b0;
      nframes = 0;
      foreach (tx_last[p]) if (tx_last[p]) nframes++;
      for (int cyc = 0; cyc < budget && done < nframes; cyc++) begin
         @(negedge clk);
         if (idx < tx_bit.size()) begin
            in_valid = 1'b1; in_bit = tx_bit[idx]; in_last = tx_last[idx];
         end else begin
            in_valid = 1'b0; in_bit = 1'($urandom); in_last = 1'b0;
         end
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (held) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_sym", out_sym, h_sym);
            chk("hold_last", out_last, h_last);
            chk("hold_tail", out_tail, h_tail);
         end
         held = out_valid && !out_ready;
         h_sym = out_sym; h_last = out_last; h_tail = out_tail;
         if (!in_ready) ready_low++;
         if (in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end
         if (out_valid && out_ready) begin
            rx_sym.push_back(out_sym);
            rx_tail.push_back(out_tail);
            rx_last.push_back(out_last);
            rx_cyc.push_back(cyc);
            if (out_last) done++;
         end
      end
      chk("frames_done", done, nframes);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
   endtask

   task automatic compare_stream(input string tag);
      int n;
      chk({tag, "_count"}, rx_sym.size(), exp_sym.size());
      n = (rx_sym.size() < exp_sym.size()) ? rx_sym.size() : exp_sym.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_sym"}, rx_sym[i], exp_sym[i]);
         chk({tag, "_tail"}, rx_tail[i], exp_tail[i]);
         chk({tag, "_last"}, rx_last[i], exp_last[i]);
      end
   endtask

   task automatic check_impulse(input string tag);
      chk({tag, "_count"}, rx_sym.size(), 5);
      if (rx_sym.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk({tag, "_sym"}, rx_sym[i], imp_sym[i]);
            chk({tag, "_tail"}, rx_tail[i], imp_tail[i]);
            chk({tag, "_last"}, rx_last[i], (i == 4));
            chk({tag, "_consec"}, rx_cyc[i], rx_cyc[0] + i);
         end
      end
      chk({tag, "_ready_low"}, ready_low, 4);
      chk({tag, "_state"}, enc_state, 4'd0);
   endtask

   initial begin
      int lasts;
      imp_sym[0] = 2'b11; imp_sym[1] = 2'b01; imp_sym[2] = 2'b10;
      imp_sym[3] = 2'b10; imp_sym[4] = 2'b11;
      imp_tail[0] = 1'b0; imp_tail[1] = 1'b1; imp_tail[2] = 1'b1;
      imp_tail[3] = 1'b1; imp_tail[4] = 1'b1;

      rst = 1'b1;
      in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_valid_z = 1'b0; in_bit_z = 1'b0; in_last_z = 1'b0; out_ready_z = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_sym", out_sym, 2'b00);
      chk("rst_last", out_last, 1'b0);
      chk("rst_tail", out_tail, 1'b0);
      chk("rst_state", enc_state, 4'd0);
      chk("rst_valid_z", out_valid_z, 1'b0);
      chk("rst_state_z", enc_state_z, 4'd0);
      rst = 1'b0;

      // impulse response
      tx_bit.delete(); tx_last.delete();
      tx_bit.push_back(1'b1); tx_last.push_back(1'b1);
      run(1'b0, 50);
      check_impulse("imp");

      // random 64-bit frame, no stalls
      tx_bit.delete(); tx_last.delete();
      for (int i = 0; i < 64; i++) begin
         tx_bit.push_back(1'($urandom));
         tx_last.push_back(i == 63);
      end
      build_expected(1'b1);
      run(1'b0, 300);
      compare_stream("rnd");
      chk("rnd_len", rx_sym.size(), 68);
      lasts = 0;
      foreach (rx_last[i]) if (rx_last[i]) lasts++;
      chk("rnd_nlast", lasts, 1);
      chk("rnd_state", enc_state, 4'd0);

      // same frame with random backpressure
      run(1'b1, 1000);
      compare_stream("bp");
      chk("bp_state", enc_state, 4'd0);

      // back-to-back frames A=1,0,1 and B=1
      tx_bit.delete(); tx_last.delete();
      tx_bit.push_back(1'b1); tx_last.push_back(1'b0);
      tx_bit.push_back(1'b0); tx_last.push_back(1'b0);
      tx_bit.push_back(1'b1); tx_last.push_back(1'b1);
      tx_bit.push_back(1'b1); tx_last.push_back(1'b1);
      build_expected(1'b1);
      run(1'b0, 100);
      compare_stream("b2b");
      chk("b2b_nacc", acc_cyc.size(), 4);
      if (acc_cyc.size() == 4 && rx_cyc.size() >= 8) begin
         chk("b2b_accept_cyc", acc_cyc[3], rx_cyc[6]);
         chk("b2b_b_first", rx_sym[7], 2'b11);
      end

      // reset during the second tail symbol
      @(negedge clk);
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rt_pre_tail", out_tail, 1'b1);
      chk("rt_pre_sym", out_sym, 2'b10);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rt_valid", out_valid, 1'b0);
      chk("rt_state", enc_state, 4'd0);
      chk("rt_ready", in_ready, 1'b1);
      rst = 1'b0;
      tx_bit.delete(); tx_last.delete();
      tx_bit.push_back(1'b1); tx_last.push_back(1'b1);
      run(1'b0, 50);
      check_impulse("rt_imp");

      // no-tail instance: frame 1,1
      @(negedge clk);
      in_valid_z = 1'b1; in_bit_z = 1'b1; in_last_z = 1'b0; out_ready_z = 1'b1;
      #1;
      chk("nt_ready", in_ready_z, 1'b1);
      @(negedge clk);
      #1;
      chk("nt_valid0", out_valid_z, 1'b1);
      chk("nt_sym0", out_sym_z, 2'b11);
      chk("nt_last0", out_last_z, 1'b0);
      chk("nt_tail0", out_tail_z, 1'b0);
      in_last_z = 1'b1;
      @(negedge clk);
      #1;
      chk("nt_valid1", out_valid_z, 1'b1);
      chk("nt_sym1", out_sym_z, 2'b10);
      chk("nt_last1", out_last_z, 1'b1);
      chk("nt_tail1", out_tail_z, 1'b0);
      chk("nt_state", enc_state_z, 4'd0);
      in_valid_z = 1'b0; in_last_z = 1'b0;
      @(negedge clk);
      #1;
      chk("nt_valid_end", out_valid_z, 1'b0);
      chk("nt_tail_end", out_tail_z, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2 convolutional encoder that produces the coded symbol stream consumed by the Viterbi decoder datapath (branch metrics → ACS → path-metric bank → traceback). It accepts one information bit per handshake and emits one 2-bit symbol per handshake. At the end of each frame it appends M zero tail bits, so every frame ends in trellis state 0. Every frame also starts in state 0. This matches the decoder's per-frame metric initialisation, where state 0 has metric 0 and all other states have the maximum metric.

Parameters:
K, 5, constraint length
M, K-1, encoder memory (number of tail bits)
G0, 5'b10011 (octal 23), generator for out_sym[0]; bit i taps input delayed by i cycles
G1, 5'b11101 (octal 35), generator for out_sym[1]; same tap convention
TAIL_EN, 1, 1 = append M zero tail bits per frame; 0 = no tail, frame ends on last data symbol

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  information bit valid
in_ready  output  1  encoder can accept in_bit this cycle
in_bit  input  1  information bit
in_last  input  1  marks the final information bit of the frame
out_valid  output  1  out_sym valid
out_ready  input  1  downstream accepts out_sym this cycle
out_sym  output  2  coded symbol {c1,c0}
out_last  output  1  final symbol of the frame (last tail symbol, or last data symbol if TAIL_EN=0)
out_tail  output  1  current symbol is a tail symbol
enc_state  output  M  current shift-register contents (encoder trellis state), for debug/scoreboard

Behaviour:
- Clock, reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs and internal registers go to 0 on reset. out_valid=0, out_sym=0, out_last=0, out_tail=0, enc_state=0, FSM=IDLE.
- Reset mid-frame: abandons the frame immediately. Any held output symbol is dropped, and the next accepted bit starts a new frame from state 0.
- Shift register sr[M-1:0]: sr[0] holds the newest bit.
- Tap vector: u = {sr, b}, where b is the current bit (in_bit, or 0 during tail). So u[0]=b and u[i]=sr[i-1].
- Symbol arithmetic: c0 = XOR-reduce(G0 & u); c1 = XOR-reduce(G1 & u).
- Shift update on advance: sr <= {sr[M-2:0], b}.
- Advance condition: adv = !out_valid || out_ready. The output is a single register stage. The encoder never advances while a symbol is held and stalled.
- FSM states:
  - IDLE: sr=0. in_ready=adv. On in_valid&&in_ready, register the symbol.
    - If in_last=0: go to DATA.
    - If in_last=1: go to TAIL when TAIL_EN=1; stay in IDLE with out_last=1 when TAIL_EN=0.
  - DATA: in_ready=adv. On accept, register the symbol.
    - If in_last=1: go to TAIL (TAIL_EN=1), or go to IDLE with out_last=1 and sr cleared to 0 (TAIL_EN=0).
    - With no accept, sr and state hold.
  - TAIL: in_ready=0. Input is ignored and must be held by upstream.
    - Each cycle with adv=1: register the symbol for b=0, set out_tail=1, increment tail_cnt.
    - When tail_cnt reaches M-1 on an advance, the registered symbol also gets out_last=1, tail_cnt clears, and the FSM goes to IDLE.
    - After M tail symbols, sr=0.
- Latency: a bit accepted in cycle t produces its symbol with out_valid=1 in cycle t+1.
- Output hold rule: out_sym, out_last and out_tail are stable while out_valid && !out_ready. out_valid deasserts only after acceptance with no new symbol registered.
- Throughput: 1 symbol/cycle with out_ready tied high. A frame of N bits produces N+M symbols; the first bit of the next frame is accepted in the cycle after the last tail symbol is registered.
- in_last on the first bit of a frame is legal (N=1).
- enc_state reflects sr after the update.

Test Plan:
1. Impulse: after reset, send in_bit=1 with in_last=1, out_ready=1. Required: out_sym sequence 2'b11, 2'b01, 2'b10, 2'b10, 2'b11 on consecutive cycles; out_tail=0,1,1,1,1; out_last only on the 5th symbol; enc_state=0 at end; in_ready=0 for 4 cycles.
2. Random frame: 64 random bits with out_ready=1. Required: symbols match a bit-exact reference model, 68 symbols total, exactly one out_last, final enc_state=0.
3. Backpressure: toggle out_ready pseudo-randomly (50%) during frame 2's data and tail. Required: out_sym held stable while stalled, no symbol lost or duplicated, same 68-symbol stream as with no stalls.
4. Back-to-back frames: frame A = 1,0,1 and frame B = 1, with in_valid held high. Required: B's first bit is accepted the cycle after A's last tail symbol is registered; B's first symbol is 2'b11 (state restarted at 0).
5. Reset mid-tail: assert rst during the 2nd tail symbol. Required: next cycle out_valid=0 and enc_state=0; a new frame of bit 1 reproduces test 1's output exactly.
6. TAIL_EN=0: frame 1,1 gives out_sym 2'b11, then 2'b10 with out_last=1, and out_tail is never 1.
